// File: rtl/seg_scan_decoder_if.sv
// Sample bus from a multiplexed 4-digit 7-segment display and the decoded frame/status outputs.
interface seg_scan_decoder_if;
  logic [3:0]  sela;
  logic [7:0]  led;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        changed;
  logic        seg_err;
  logic        sel_err;
  logic        stale;

  modport master (output sela, led,
                  input  value, dp, frame_valid, changed, seg_err, sel_err, stale);
  modport slave  (input  sela, led,
                  output value, dp, frame_valid, changed, seg_err, sel_err, stale);
endinterface

// File: rtl/seg_scan_decoder.sv
// Decodes a scanned 4-digit 7-segment display back into a 16-bit BCD frame with status flags.
// Optional feature: define SEG_DP_EN to capture per-digit decimal points on dp.
module seg_scan_decoder #(
  parameter int SETTLE  = 1,
  parameter int TIMEOUT = 1024
) (
  input logic               clock,
  input logic               reset,
  seg_scan_decoder_if.slave bus
);
  localparam int STAGES = 1;
  localparam int CW     = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [3:0] sela;
    logic [7:0] led;
  } smp_t;

  smp_t            smp, prv;
  logic [STAGES:0] vld_pipe;
  logic [4:0]      run, run_nx;
  logic [3:0][3:0] slot, slot_nx;
  logic [3:0]      seen, seen_nx;
  logic [15:0]     value;
  logic            frame_valid, changed, seg_err, sel_err, have_frame;
  logic [CW-1:0]   stale_cnt;
  logic [3:0]      digit;
  logic [1:0]      idx;
  logic            code_ok, accept, blank, one_low, wr, bad_seg, bad_sel, done, differs;
`ifdef SEG_DP_EN
  logic [3:0]      dps, dps_nx, dp;
`endif

  always_comb begin
    digit   = 4'd0;
    code_ok = 1'b1;
    case (smp.led[6:0])
      7'h3F: digit = 4'd0;
      7'h06: digit = 4'd1;
      7'h5B: digit = 4'd2;
      7'h4F: digit = 4'd3;
      7'h66: digit = 4'd4;
      7'h6D: digit = 4'd5;
      7'h7D: digit = 4'd6;
      7'h07: digit = 4'd7;
      7'h7F: digit = 4'd8;
      7'h6F: digit = 4'd9;
      default: code_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (smp.sela)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // Run counter saturates at 16 so a held sample matches SETTLE (<=15) exactly once.
  always_comb begin
    run_nx = 5'd1;
    if (vld_pipe[1] && smp == prv) run_nx = (run == 5'd16) ? run : run + 5'd1;
    accept  = vld_pipe[0] && (run_nx == 5'(SETTLE));
    blank   = (smp.sela == 4'hF);
    one_low = $onehot(~smp.sela);
    wr      = accept && one_low && code_ok;
    bad_seg = accept && one_low && !code_ok;
    bad_sel = accept && !blank && !one_low;
    slot_nx = slot;
    seen_nx = seen;
    if (wr) begin
      slot_nx[idx] = digit;
      seen_nx[idx] = 1'b1;
    end
    done = wr && (seen_nx == 4'hF);
  end

`ifdef SEG_DP_EN
  always_comb begin
    dps_nx = dps;
    if (wr) dps_nx[idx] = smp.led[7];
  end
  assign differs = ({slot_nx, dps_nx} != {value, dp});
`else
  assign differs = (slot_nx != value);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      smp         <= '0;
      prv         <= '0;
      vld_pipe    <= '0;
      run         <= '0;
      slot        <= '0;
      seen        <= '0;
      value       <= '0;
      frame_valid <= 1'b0;
      changed     <= 1'b0;
      seg_err     <= 1'b0;
      sel_err     <= 1'b0;
      have_frame  <= 1'b0;
      stale_cnt   <= '0;
    end else begin
      smp         <= {bus.sela, bus.led};
      prv         <= smp;
      vld_pipe    <= {vld_pipe[STAGES-1:0], 1'b1};
      run         <= run_nx;
      slot        <= slot_nx;
      frame_valid <= done;
      seg_err     <= bad_seg;
      sel_err     <= bad_sel;
      changed     <= 1'b0;
      // A bad pattern drops the partial frame; stale slots get rewritten before the next completion.
      seen        <= (bad_seg || done) ? 4'h0 : seen_nx;
      if (done) begin
        value      <= slot_nx;
        changed    <= !have_frame || differs;
        have_frame <= 1'b1;
        stale_cnt  <= '0;
      end else if (stale_cnt != CW'(TIMEOUT)) begin
        stale_cnt  <= stale_cnt + 1'b1;
      end
    end
  end

`ifdef SEG_DP_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      dps <= '0;
      dp  <= '0;
    end else begin
      dps <= dps_nx;
      if (done) dp <= dps_nx;
    end
  end
  assign bus.dp = dp;
`else
  assign bus.dp = 4'h0;
`endif

  assign bus.value       = value;
  assign bus.frame_valid = frame_valid;
  assign bus.changed     = changed;
  assign bus.seg_err     = seg_err;
  assign bus.sel_err     = sel_err;
  assign bus.stale       = (stale_cnt == CW'(TIMEOUT));
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: table-driven scans scored through an expectation queue, plus SETTLE=2 and reset sequences.
module tb_seg_scan_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

`ifdef SEG_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  seg_scan_decoder_if bus1();
  seg_scan_decoder_if bus2();

  seg_scan_decoder #(.SETTLE(1), .TIMEOUT(1024)) dut1 (.clock(clk), .reset(reset), .bus(bus1.slave));
  seg_scan_decoder #(.SETTLE(2), .TIMEOUT(1024)) dut2 (.clock(clk), .reset(reset), .bus(bus2.slave));

  typedef struct {
    logic [3:0]  sela;
    logic [7:0]  led;
    logic        fv, ch, se, sl;
    logic [15:0] val;
    logic [3:0]  dp;
  } vec_t;

  typedef struct {
    int          due;
    logic        fv, ch, se, sl;
    logic [15:0] val;
    logic [3:0]  dp;
  } exp_t;

  vec_t tbl[$];
  exp_t q[$];
  int   cyc = 0, checks = 0, errors = 0, last_clear = 0;
  bit   rst_q = 1'b1, mon_en = 1'b0;
  int   nfv, nse, nsl;
  logic [15:0] v2;
  logic        c2;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic add(input logic [3:0] s, input logic [7:0] l, input logic fv, input logic ch,
                     input logic se, input logic sl, input logic [15:0] v, input logic [3:0] d);
    tbl.push_back('{s, l, fv, ch, se, sl, v, d});
  endtask

  // Full scan d0..d3; the frame lands on the last digit.
  task automatic add_scan(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                          input logic [7:0] l3, input logic ch, input logic [15:0] v, input logic [3:0] d);
    add(4'b1110, l0, 0, 0, 0, 0, 16'h0, 4'h0);
    add(4'b1101, l1, 0, 0, 0, 0, 16'h0, 4'h0);
    add(4'b1011, l2, 0, 0, 0, 0, 16'h0, 4'h0);
    add(4'b0111, l3, 1, ch, 0, 0, v, d);
  endtask

  // Inputs set after edge c are sampled at c+1 and accepted at c+2 (SETTLE=1).
  task automatic drive1(input vec_t v);
    @(posedge clk); #2;
    bus1.sela = v.sela;
    bus1.led  = v.led;
    if (v.fv || v.se || v.sl) q.push_back('{cyc + 2, v.fv, v.ch, v.se, v.sl, v.val, v.dp});
  endtask

  task automatic step2(input logic [3:0] s, input logic [7:0] l);
    @(posedge clk); #2;
    bus2.sela = s;
    bus2.led  = l;
    @(negedge clk);
    if (bus2.frame_valid === 1'b1) begin
      nfv++;
      v2 = bus2.value;
      c2 = bus2.changed;
    end
    if (bus2.seg_err === 1'b1) nse++;
    if (bus2.sel_err === 1'b1) nsl++;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_q) last_clear = cyc;
    if (mon_en) begin
      if (rst_q) begin
        chk("reset_state", 32'({bus1.value, bus1.dp, bus1.frame_valid, bus1.changed,
                                bus1.seg_err, bus1.sel_err, bus1.stale}), 32'd0);
      end else begin
        e = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0};
        if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
        if (e.fv) last_clear = cyc;
        chk("pulses", 32'({bus1.frame_valid, bus1.changed, bus1.seg_err, bus1.sel_err}),
            32'({e.fv, e.ch, e.se, e.sl}));
        if (e.fv) begin
          chk("value", 32'(bus1.value), 32'(e.val));
          chk("dp", 32'(bus1.dp), 32'(e.dp));
        end
        chk("stale", 32'(bus1.stale), 32'((cyc - last_clear) >= 1024));
      end
    end
  end

  initial begin
    logic [7:0] codes[4];
    logic [3:0] s;
    codes[0] = 8'h06; codes[1] = 8'h5B; codes[2] = 8'h4F; codes[3] = 8'h66;
    bus1.sela = 4'hF; bus1.led = 8'h00;
    bus2.sela = 4'hF; bus2.led = 8'h00;

    add_scan(8'h06, 8'h5B, 8'h4F, 8'h66, 1, 16'h4321, 4'h0);
    add_scan(8'h06, 8'h5B, 8'h4F, 8'h66, 0, 16'h4321, 4'h0);
    add(4'b1110, 8'h06, 0, 0, 0, 0, 16'h0, 4'h0);
    add(4'b1101, 8'h5B, 0, 0, 0, 0, 16'h0, 4'h0);
    add(4'b1011, 8'h00, 0, 0, 1, 0, 16'h0, 4'h0);
    add(4'b1011, 8'h00, 0, 0, 0, 0, 16'h0, 4'h0);
    add(4'b0111, 8'h66, 0, 0, 0, 0, 16'h0, 4'h0);
    add(4'b1110, 8'h06, 0, 0, 0, 0, 16'h0, 4'h0);
    add(4'b1101, 8'h5B, 0, 0, 0, 0, 16'h0, 4'h0);
    add(4'b1011, 8'h4F, 1, 0, 0, 0, 16'h4321, 4'h0);
    add(4'b0111, 8'h66, 0, 0, 0, 0, 16'h0, 4'h0);
    add(4'b1110, 8'h08, 0, 0, 1, 0, 16'h0, 4'h0);
    add_scan(8'h3F, 8'h07, 8'h7F, 8'h6F, 1, 16'h9870, 4'h0);
    add_scan(8'h6D, 8'h7D, 8'h5B, 8'h06, 1, 16'h1265, 4'h0);
    add(4'b1110, 8'h06, 0, 0, 0, 0, 16'h0, 4'h0);
    add(4'b1111, 8'h00, 0, 0, 0, 0, 16'h0, 4'h0);
    add(4'b1101, 8'h5B, 0, 0, 0, 0, 16'h0, 4'h0);
    add(4'b1100, 8'h4F, 0, 0, 0, 1, 16'h0, 4'h0);
    add(4'b1100, 8'h4F, 0, 0, 0, 0, 16'h0, 4'h0);
    add(4'b1011, 8'h4F, 0, 0, 0, 0, 16'h0, 4'h0);
    add(4'b0000, 8'hFF, 0, 0, 0, 1, 16'h0, 4'h0);
    add(4'b0111, 8'h66, 1, 1, 0, 0, 16'h4321, 4'h0);
    add_scan(8'h86, 8'h5B, 8'h4F, 8'h66, DP_EN, 16'h4321, DP_EN ? 4'h1 : 4'h0);
    add_scan(8'h86, 8'h5B, 8'h4F, 8'h66, 0, 16'h4321, DP_EN ? 4'h1 : 4'h0);
    add(4'b1110, 8'h06, 0, 0, 0, 0, 16'h0, 4'h0);
    add_scan(8'h3F, 8'h5B, 8'h4F, 8'h66, 1, 16'h4320, 4'h0);

    repeat (3) @(posedge clk);
    #2;
    mon_en = 1'b1;
    reset  = 1'b0;

    foreach (tbl[i]) drive1(tbl[i]);

    // Idle long enough for the stale counter to saturate, then a fresh frame clears it.
    for (int i = 0; i < 1030; i++) drive1('{4'hF, 8'h00, 0, 0, 0, 0, 16'h0, 4'h0});
    @(negedge clk);
    chk("stale_hold", 32'(bus1.stale), 32'd1);
    drive1('{4'b1110, 8'h6D, 0, 0, 0, 0, 16'h0, 4'h0});
    drive1('{4'b1101, 8'h6D, 0, 0, 0, 0, 16'h0, 4'h0});
    drive1('{4'b1011, 8'h6D, 0, 0, 0, 0, 16'h0, 4'h0});
    drive1('{4'b0111, 8'h6D, 1, 1, 0, 0, 16'h5555, 4'h0});
    for (int i = 0; i < 4; i++) drive1('{4'hF, 8'h00, 0, 0, 0, 0, 16'h0, 4'h0});
    @(negedge clk);
    chk("stale_after_frame", 32'(bus1.stale), 32'd0);

    // SETTLE=2: each digit preceded by a one-cycle invalid glitch on the same select.
    nfv = 0; nse = 0; nsl = 0; v2 = '0; c2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s = ~(4'b0001 << k);
      step2(s, 8'h00);
      step2(s, codes[k]);
      step2(s, codes[k]);
    end
    for (int i = 0; i < 4; i++) step2(4'hF, 8'h00);
    chk("s2_frames", 32'(nfv), 32'd1);
    chk("s2_value", 32'(v2), 32'h4321);
    chk("s2_changed", 32'(c2), 32'd1);
    chk("s2_glitch_errs", 32'(nse + nsl), 32'd0);

    // Reset after two digits drops the partial frame.
    step2(4'b1110, codes[0]); step2(4'b1110, codes[0]);
    step2(4'b1101, codes[1]); step2(4'b1101, codes[1]);
    step2(4'hF, 8'h00);
    @(posedge clk); #2; reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0;
    @(negedge clk);
    chk("s2_reset_state", 32'({bus2.value, bus2.dp, bus2.frame_valid, bus2.changed,
                               bus2.seg_err, bus2.sel_err, bus2.stale}), 32'd0);
    nfv = 0; nse = 0;
    step2(4'b1011, codes[2]); step2(4'b1011, codes[2]);
    step2(4'b0111, codes[3]); step2(4'b0111, codes[3]);
    for (int i = 0; i < 4; i++) step2(4'hF, 8'h00);
    chk("s2_no_frame_after_reset", 32'(nfv), 32'd0);
    chk("s2_value_after_reset", 32'(bus2.value), 32'h0);

    repeat (3) @(posedge clk);
    chk("sb_drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the multiplexed 4-digit 7-segment display driver. The block samples the time-multiplexed digit-select and segment buses each clock and decodes the lit segment patterns back to BCD. It reassembles the four digits into a 16-bit BCD value and reports completed frames, changes, bad patterns and loss of scanning. It sits in the self-check path beside the display driver and also serves as a display-monitor front end.

## Interface
- SETTLE, 1: consecutive identical samples (sela, led) required before a digit is accepted; 1..15.
- TIMEOUT, 1024: cycles without a completed frame before `stale` asserts; ≥ 2.
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- sela  input  4  digit select, active-low one-hot; bit0 low = digit 0 (least significant).
- led  input  8  segments {dp,g,f,e,d,c,b,a}, 1 = lit.
- value  output  16  last completed frame, BCD {d3,d2,d1,d0}.
- dp  output  4  decimal-point bits of the last frame, one per digit.
- frame_valid  output  1  one-cycle pulse when `value`/`dp` update.
- changed  output  1  qualifies `frame_valid`: new frame differs from previous.
- seg_err  output  1  one-cycle pulse: accepted sample had an undecodable pattern.
- sel_err  output  1  one-cycle pulse: sample had more than one `sela` bit low.
- stale  output  1  no frame for TIMEOUT cycles.

## Operation
- Stage 1: register `sela`/`led` into a sample register every cycle.
- Stage 2: run counter increments while sample equals the previous sample, else reloads to 1. A sample is accepted once, when the run count reaches SETTLE; no re-accept until the sample changes.
- Sample classification:
  - `sela`=4'b1111 (blank): ignored, no error.
  - Two or more bits low: ignored, `sel_err` pulse when accepted.
  - Exactly one bit low: decode `led[6:0]` with 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- On a valid code: write the digit into the selected slot and set that bit in `seen[3:0]`. Re-writing an already-seen slot overwrites it.
- On any other 7-bit pattern: pulse `seg_err`, clear `seen`, discard the partial frame.
- Frame completion: when an accept makes `seen`==4'b1111, on the same edge:
  - load `value`/`dp` from the slots, including the digit just accepted;
  - pulse `frame_valid`;
  - set `changed` = ({value,dp} differs from the previous frame), or 1 for the first frame after reset;
  - clear `seen`.
- Stale counter: counts cycles since the last `frame_valid` and saturates at TIMEOUT. `stale` = (count == TIMEOUT). Cleared to 0 by `frame_valid`.
- Reset, including mid-frame: sample register, run counter, slots, `seen`, stale counter and all outputs go to 0. `value`=16'h0000, `dp`=4'h0, all flags 0. Partial frame discarded.

## Timing
- Latency with SETTLE=1: inputs present before edge N are sampled at N and accepted at N+1. `value`, `frame_valid`, `changed`, `seg_err` and `sel_err` are visible after edge N+1.
- General acceptance edge is N+SETTLE.
- `frame_valid`, `seg_err` and `sel_err` are registered single-cycle pulses.
- `changed` is meaningful only while `frame_valid`=1 and is 0 otherwise.
- Back-to-back frames: a scan at one digit per clock with SETTLE=1 yields one `frame_valid` every 4 cycles.
- Simultaneous frame completion and stale saturation in the same cycle: frame wins, and `stale` reads 0 the next cycle.

## Configuration
- `SEG_DP_EN` defined: `led[7]` is stored per slot and output on `dp`. A dp change alone sets `changed`.
- `SEG_DP_EN` undefined: `led[7]` is ignored, `dp` is tied to 4'h0, and `changed` compares `value` only.
- In both cases `led[7]` never causes `seg_err`.

## Test plan
- Scan `sela` 1110/1101/1011/0111 with `led` 06/5B/4F/66, one per clock, SETTLE=1 → `frame_valid` one cycle, two edges after the 0111 sample is presented; `value`=16'h4321, `changed`=1.
- Repeat the identical scan → `frame_valid`=1, `changed`=0, `value` stays 16'h4321.
- Same scan with slot 2 `led`=8'h00 → `seg_err` pulse, no `frame_valid`; the following clean scan emits 16'h4321.
- `sela`=1100 inserted mid-scan → `sel_err` pulse, sample ignored; scan completes normally.
- Hold `sela`=1111 for 1024 cycles after a frame → `stale`=1 on cycle 1024; next full scan → `stale`=0.
- SETTLE=2 with a one-cycle glitch per digit → only stable samples accepted. Reset after two digits → all outputs 0, and a single completing digit does not emit a frame.
